// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: display source states,
// BCD word width and the default 1 kHz prescaler ratio.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_LIVE = 2'd0,
    ST_FRZ  = 2'd1,
    ST_MSG  = 2'd2
  } disp_state_e;

  localparam int BCD8_W     = 32;
  localparam int DIV_1K_DEF = 50000;

endpackage : seg_pkg

// File: rtl/seg_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks; the first
// tick appears DIV cycles after reset is released.
module seg_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int            DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_div;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div  <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= (r_div == DIV_LAST);
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end
  end

endmodule : seg_tick_gen

// File: rtl/seg_disp_ctrl.sv
// Display source scheduler: selects live, frozen snapshot or timed message word
// for the digit scanner and provides the shared 1 kHz scan tick.
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int DIV_1K  = DIV_1K_DEF,
  parameter int HOLD_MS = 2000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BCD8_W-1:0] i_bcd_live,
  input  logic              i_frz_tgl,
  input  logic              i_msg_req,
  input  logic [BCD8_W-1:0] i_msg_bcd,
  output logic              o_msg_ack,
  output logic              o_msg_busy,
  output logic              o_frozen,
  output logic              o_pls_1k,
  output logic [BCD8_W-1:0] o_bcd8d
);

  localparam int              MS_W      = $clog2(HOLD_MS + 1);
  localparam logic [MS_W-1:0] HOLD_LAST = MS_W'(HOLD_MS - 1);

  disp_state_e       state_q, state_d;
  logic              r_frz, frz_d;
  logic [BCD8_W-1:0] r_snap, snap_d;
  logic [BCD8_W-1:0] r_msg, msg_d;
  logic [MS_W-1:0]   r_ms, ms_d;
  logic [BCD8_W-1:0] bcd_d;
  logic              accept;

  seg_tick_gen #(.DIV(DIV_1K)) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (o_pls_1k)
  );

  // NOTE: every signal driven here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    accept  = i_msg_req && !o_msg_ack;
    frz_d   = r_frz ^ i_frz_tgl;
    snap_d  = (i_frz_tgl && !r_frz) ? i_bcd_live : r_snap;
    msg_d   = r_msg;
    ms_d    = r_ms;
    state_d = state_q;

    // An accept overrides a simultaneous hold expiry and restarts the hold.
    if (accept) begin
      msg_d   = i_msg_bcd;
      ms_d    = '0;
      state_d = ST_MSG;
    end else if (state_q == ST_MSG) begin
      if (o_pls_1k) begin
        if (r_ms == HOLD_LAST) begin
          ms_d    = '0;
          state_d = frz_d ? ST_FRZ : ST_LIVE;
        end else begin
          ms_d = r_ms + MS_W'(1);
        end
      end
    end else begin
      state_d = frz_d ? ST_FRZ : ST_LIVE;
    end

    // Output word is taken from the next-state view so a source change shows one cycle later.
    unique case (state_d)
      ST_FRZ:  bcd_d = snap_d;
      ST_MSG:  bcd_d = msg_d;
      default: bcd_d = i_bcd_live;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_LIVE;
      r_frz      <= 1'b0;
      r_snap     <= '0;
      r_msg      <= '0;
      r_ms       <= '0;
      o_msg_ack  <= 1'b0;
      o_msg_busy <= 1'b0;
      o_bcd8d    <= '0;
    end else begin
      state_q    <= state_d;
      r_frz      <= frz_d;
      r_snap     <= snap_d;
      r_msg      <= msg_d;
      r_ms       <= ms_d;
      o_msg_ack  <= accept;
      o_msg_busy <= (state_d == ST_MSG);
      o_bcd8d    <= bcd_d;
    end
  end

  assign o_frozen = r_frz;

endmodule : seg_disp_ctrl
